// File: rtl/nibble_bus_pkg.sv
// Shared definitions for the nibble bus controller: nibble width, FSM
// state encoding and an access-latency helper.
package nibble_bus_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  // Cycles from the edge that samples req to the cycle in which done is high.
  function automatic int access_latency(input int nibbles, input int wait_states);
    return nibbles * (1 + wait_states) + 1;
  endfunction

endpackage

// File: rtl/nibble_bus_wait_cnt.sv
// Per-nibble cycle counter. Counts 0..WAIT_STATES while enabled and flags the
// cycle in which the current nibble completes. A stall in that final cycle
// holds the counter so the cycle repeats.
module nibble_bus_wait_cnt #(
  parameter int WAIT_STATES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic stall,
  output logic last_cycle
);

  localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_STATES);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic             at_max_s;

  // Next count and completion flag; the counter rewinds after each nibble.
  always_comb begin
    at_max_s   = (cnt_r == CNT_MAX);
    last_cycle = en & at_max_s & ~stall;
    cnt_s      = cnt_r;
    if (!en) begin
      cnt_s = '0;
    end else if (at_max_s) begin
      if (stall) begin
        cnt_s = cnt_r;
      end else begin
        cnt_s = '0;
      end
    end else begin
      cnt_s = cnt_r + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_s;
    end
  end

endmodule

// File: rtl/nibble_bus_ctrl.sv
// Bus interface unit: splits a core word access into NIBBLES transfers on a
// 4-bit external bus at consecutive nibble addresses, assembles read data
// little-endian and pulses done for one cycle. All outputs are registered.
// Optional macro NIBBLE_BUS_WAIT_EN adds a bus_wait input that stretches the
// final cycle of a nibble for as long as it is asserted.
module nibble_bus_ctrl
  import nibble_bus_pkg::*;
#(
  parameter int ADDR_W      = 11,
  parameter int NIBBLES     = 2,
  parameter int WAIT_STATES = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [NIBBLE_W*NIBBLES-1:0] wdata,
  output logic [NIBBLE_W*NIBBLES-1:0] rdata,
  output logic                       done,
  output logic                       busy,
  output logic [ADDR_W-1:0]          bus_addr,
  output logic                       bus_data_rw,
  output logic [NIBBLE_W-1:0]        bus_data_out,
`ifdef NIBBLE_BUS_WAIT_EN
  input  logic                       bus_wait,
`endif
  input  logic [NIBBLE_W-1:0]        bus_data_in
);

  localparam int WORD_W = NIBBLE_W * NIBBLES;
  localparam int IDX_W  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t              state_r, state_s;
  logic [IDX_W-1:0]    idx_r, idx_s;
  logic                we_r, we_s;
  logic [ADDR_W-1:0]   addr_r, addr_s;
  logic [WORD_W-1:0]   wdata_r, wdata_s;
  logic [WORD_W-1:0]   rdata_r, rdata_s;
  logic                done_r, done_s;
  logic                busy_r, busy_s;
  logic [ADDR_W-1:0]   bus_addr_r, bus_addr_s;
  logic                rw_r, rw_s;
  logic [NIBBLE_W-1:0] out_r, out_s;
  logic                last_cycle_s;
  logic                stall_s;

`ifdef NIBBLE_BUS_WAIT_EN
  assign stall_s = bus_wait;
`else
  assign stall_s = 1'b0;
`endif

  nibble_bus_wait_cnt #(
    .WAIT_STATES (WAIT_STATES)
  ) u_wait_cnt (
    .clk        (clk),
    .rst        (rst),
    .en         (state_r == XFER),
    .stall      (stall_s),
    .last_cycle (last_cycle_s)
  );

  // Next-state and next-output logic; outputs are computed one cycle ahead
  // so that every port comes straight from a flop.
  always_comb begin
    state_s    = state_r;
    idx_s      = idx_r;
    we_s       = we_r;
    addr_s     = addr_r;
    wdata_s    = wdata_r;
    rdata_s    = rdata_r;
    done_s     = 1'b0;
    busy_s     = busy_r;
    bus_addr_s = bus_addr_r;
    rw_s       = rw_r;
    out_s      = out_r;
    case (state_r)
      IDLE: begin
        if (req) begin
          state_s    = XFER;
          we_s       = we;
          addr_s     = addr;
          wdata_s    = wdata;
          idx_s      = '0;
          busy_s     = 1'b1;
          bus_addr_s = addr;
          rw_s       = we;
          out_s      = we ? wdata[NIBBLE_W-1:0] : NIBBLE_W'(0);
        end else begin
          state_s = IDLE;
          busy_s  = 1'b0;
          rw_s    = 1'b0;
          out_s   = NIBBLE_W'(0);
        end
      end
      XFER: begin
        busy_s = 1'b1;
        if (last_cycle_s) begin
          if (!we_r) begin
            rdata_s[NIBBLE_W*idx_r +: NIBBLE_W] = bus_data_in;
          end else begin
            rdata_s = rdata_r;
          end
          if (idx_r == LAST_IDX) begin
            state_s = DONE;
            done_s  = 1'b1;
            rw_s    = 1'b0;
            out_s   = NIBBLE_W'(0);
          end else begin
            idx_s      = idx_r + IDX_W'(1);
            bus_addr_s = addr_r + ADDR_W'(idx_s);
            rw_s       = we_r;
            out_s      = we_r ? wdata_r[NIBBLE_W*idx_s +: NIBBLE_W] : NIBBLE_W'(0);
          end
        end else begin
          state_s = XFER;
        end
      end
      DONE: begin
        state_s = IDLE;
        busy_s  = 1'b0;
        rw_s    = 1'b0;
        out_s   = NIBBLE_W'(0);
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
        rw_s    = 1'b0;
        out_s   = NIBBLE_W'(0);
      end
    endcase
  end

  // State, latched request and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      idx_r      <= '0;
      we_r       <= 1'b0;
      addr_r     <= '0;
      wdata_r    <= '0;
      rdata_r    <= '0;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
      bus_addr_r <= '0;
      rw_r       <= 1'b0;
      out_r      <= '0;
    end else begin
      state_r    <= state_s;
      idx_r      <= idx_s;
      we_r       <= we_s;
      addr_r     <= addr_s;
      wdata_r    <= wdata_s;
      rdata_r    <= rdata_s;
      done_r     <= done_s;
      busy_r     <= busy_s;
      bus_addr_r <= bus_addr_s;
      rw_r       <= rw_s;
      out_r      <= out_s;
    end
  end

  assign rdata        = rdata_r;
  assign done         = done_r;
  assign busy         = busy_r;
  assign bus_addr     = bus_addr_r;
  assign bus_data_rw  = rw_r;
  assign bus_data_out = out_r;

endmodule

// File: tb/tb_nibble_bus_ctrl.sv
// Directed self-checking bench for nibble_bus_ctrl: a default-parameter
// instance backed by a nibble memory, and a WAIT_STATES=2 instance whose read
// data is driven cycle by cycle.
module tb_nibble_bus_ctrl;
  import nibble_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        req_ws;
  logic        we;
  logic [10:0] addr;
  logic [7:0]  wdata;

  logic [7:0]  rdata, rdata_ws;
  logic        done, done_ws;
  logic        busy, busy_ws;
  logic [10:0] bus_addr, bus_addr_ws;
  logic        bus_data_rw, bus_data_rw_ws;
  logic [3:0]  bus_data_out, bus_data_out_ws;
  logic [3:0]  bus_data_in;
  logic [3:0]  din_ws;
`ifdef NIBBLE_BUS_WAIT_EN
  logic        bus_wait;
`endif

  logic [3:0]  mem [0:2047];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign bus_data_in = mem[bus_addr];

  nibble_bus_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .we           (we),
    .addr         (addr),
    .wdata        (wdata),
    .rdata        (rdata),
    .done         (done),
    .busy         (busy),
    .bus_addr     (bus_addr),
    .bus_data_rw  (bus_data_rw),
    .bus_data_out (bus_data_out),
`ifdef NIBBLE_BUS_WAIT_EN
    .bus_wait     (bus_wait),
`endif
    .bus_data_in  (bus_data_in)
  );

  nibble_bus_ctrl #(.WAIT_STATES(2)) dut_ws (
    .clk          (clk),
    .rst          (rst),
    .req          (req_ws),
    .we           (we),
    .addr         (addr),
    .wdata        (wdata),
    .rdata        (rdata_ws),
    .done         (done_ws),
    .busy         (busy_ws),
    .bus_addr     (bus_addr_ws),
    .bus_data_rw  (bus_data_rw_ws),
    .bus_data_out (bus_data_out_ws),
`ifdef NIBBLE_BUS_WAIT_EN
    .bus_wait     (1'b0),
`endif
    .bus_data_in  (din_ws)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a request to the default instance; returns at the cycle-1 sample point.
  task automatic issue(input logic w, input logic [10:0] a, input logic [7:0] d);
    @(negedge clk);
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    @(negedge clk);
    req   = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 4'h0;
    rst    = 1'b1;
    req    = 1'b0;
    req_ws = 1'b0;
    we     = 1'b0;
    addr   = 11'h000;
    wdata  = 8'h00;
    din_ws = 4'h0;
`ifdef NIBBLE_BUS_WAIT_EN
    bus_wait = 1'b0;
`endif
    repeat (3) @(negedge clk);

    // Reset state
    check_eq("rst_rdata", rdata, 8'h00);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_addr", bus_addr, 11'h000);
    check_eq("rst_rw", bus_data_rw, 1'b0);
    check_eq("rst_out", bus_data_out, 4'h0);
    check_eq("rst_busy_ws", busy_ws, 1'b0);
    rst = 1'b0;

    // Read 0x123 with default timing
    mem[11'h123] = 4'hA;
    mem[11'h124] = 4'h5;
    issue(1'b0, 11'h123, 8'h00);
    check_eq("rd_c1_addr", bus_addr, 11'h123);
    check_eq("rd_c1_rw", bus_data_rw, 1'b0);
    check_eq("rd_c1_busy", busy, 1'b1);
    check_eq("rd_c1_done", done, 1'b0);
    @(negedge clk);
    check_eq("rd_c2_addr", bus_addr, 11'h124);
    check_eq("rd_c2_rw", bus_data_rw, 1'b0);
    check_eq("rd_c2_done", done, 1'b0);
    @(negedge clk);
    check_eq("rd_c3_done", done, 1'b1);
    check_eq("rd_c3_rdata", rdata, 8'h5A);
    check_eq("rd_c3_rw", bus_data_rw, 1'b0);
    @(negedge clk);
    check_eq("rd_c4_done", done, 1'b0);
    check_eq("rd_c4_busy", busy, 1'b0);
    check_eq("rd_c4_rdata", rdata, 8'h5A);

    // Write 0xC3 at 0x040
    issue(1'b1, 11'h040, 8'hC3);
    check_eq("wr_c1_addr", bus_addr, 11'h040);
    check_eq("wr_c1_rw", bus_data_rw, 1'b1);
    check_eq("wr_c1_out", bus_data_out, 4'h3);
    @(negedge clk);
    check_eq("wr_c2_addr", bus_addr, 11'h041);
    check_eq("wr_c2_rw", bus_data_rw, 1'b1);
    check_eq("wr_c2_out", bus_data_out, 4'hC);
    @(negedge clk);
    check_eq("wr_c3_done", done, 1'b1);
    check_eq("wr_c3_rw", bus_data_rw, 1'b0);
    check_eq("wr_c3_rdata", rdata, 8'h5A);
    @(negedge clk);
    check_eq("wr_c4_busy", busy, 1'b0);

    // Address wrap 0x7FF -> 0x000
    mem[11'h7FF] = 4'h7;
    mem[11'h000] = 4'hE;
    issue(1'b0, 11'h7FF, 8'h00);
    check_eq("wrap_c1_addr", bus_addr, 11'h7FF);
    @(negedge clk);
    check_eq("wrap_c2_addr", bus_addr, 11'h000);
    @(negedge clk);
    check_eq("wrap_c3_done", done, 1'b1);
    check_eq("wrap_c3_rdata", rdata, 8'hE7);

    // WAIT_STATES=2 read: data valid only in the third cycle of each nibble
    @(negedge clk);
    req_ws = 1'b1;
    we     = 1'b0;
    addr   = 11'h200;
    din_ws = 4'hF;
    @(negedge clk);
    req_ws = 1'b0;
    for (int c = 1; c <= access_latency(2, 2); c++) begin
      if (c > 1) @(negedge clk);
      if (c < access_latency(2, 2)) begin
        check_eq("ws_addr", bus_addr_ws, 11'h200 + 11'((c - 1) / 3));
        check_eq("ws_rw", bus_data_rw_ws, 1'b0);
        check_eq("ws_done_early", done_ws, 1'b0);
        din_ws = (c % 3 == 0) ? ((c == 3) ? 4'h6 : 4'h9) : 4'hF;
      end else begin
        check_eq("ws_done", done_ws, 1'b1);
        check_eq("ws_rdata", rdata_ws, 8'h96);
      end
    end
    @(negedge clk);
    check_eq("ws_idle_busy", busy_ws, 1'b0);

    // Reset in cycle 2 of a write, then a normal read
    issue(1'b1, 11'h050, 8'h21);
    check_eq("rw_c1_addr", bus_addr, 11'h050);
    check_eq("rw_c1_out", bus_data_out, 4'h1);
    @(negedge clk);
    check_eq("rw_c2_out", bus_data_out, 4'h2);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rw_c3_rw", bus_data_rw, 1'b0);
    check_eq("rw_c3_busy", busy, 1'b0);
    check_eq("rw_c3_done", done, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rw_c4_done", done, 1'b0);
    check_eq("rw_c4_rw", bus_data_rw, 1'b0);
    issue(1'b0, 11'h123, 8'h00);
    check_eq("rw_new_addr", bus_addr, 11'h123);
    repeat (2) @(negedge clk);
    check_eq("rw_new_done", done, 1'b1);
    check_eq("rw_new_rdata", rdata, 8'h5A);

`ifdef NIBBLE_BUS_WAIT_EN
    // bus_wait held for 4 cycles on nibble 0
    issue(1'b0, 11'h123, 8'h00);
    for (int c = 1; c <= 7; c++) begin
      if (c > 1) @(negedge clk);
      if (c <= 5) begin
        check_eq("bw_addr0", bus_addr, 11'h123);
        check_eq("bw_done_early", done, 1'b0);
      end else if (c == 6) begin
        check_eq("bw_addr1", bus_addr, 11'h124);
      end else begin
        check_eq("bw_done", done, 1'b1);
        check_eq("bw_rdata", rdata, 8'h5A);
      end
      bus_wait = (c <= 4) ? 1'b1 : 1'b0;
    end
    bus_wait = 1'b0;
`endif

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
